// File: rtl/flag_wr_sched.sv
// Flag-write scheduler and branch interlock for the dual-lane core.
// Optional stall counter output br_stall_cnt when FLAG_STATS_EN is defined.
module flag_wr_sched #(
   parameter int unsigned LAT = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       hold,
   input  logic       flush,
   input  logic       issue_vld0,
   input  logic       wz0,
   input  logic       wnv0,
   input  logic       issue_vld1,
   input  logic       wz1,
   input  logic       wnv1,
   input  logic       br_id,
   input  logic [2:0] br_cc,
   output logic       clk_z_ID_EX,
   output logic       clk_nv_ID_EX,
   output logic       clk_z_ID_ext_EX,
   output logic       clk_nv_ID_ext_EX,
   output logic       br_stall,
   output logic       flags_busy
`ifdef FLAG_STATS_EN
   ,
   output logic [15:0] br_stall_cnt
`endif
);

   localparam int unsigned CNT_W = 16;

   logic [LAT-1:0] r_z0, r_nv0, r_z1, r_nv1;
   logic           w_issue_ok;
   logic           w_need_z, w_need_nv;
   logic           w_z_pend, w_nv_pend;
   logic           w_z_last0, w_z_last1, w_nv_last0, w_nv_last1;

   // Advance one stage, new entry enters at stage 0.
   function automatic logic [LAT-1:0] f_shift(input logic [LAT-1:0] v, input logic b);
      logic [LAT-1:0] s;
      s    = v << 1;
      s[0] = b;
      return s;
   endfunction

   // Flag classes read by each condition code.
   always_comb begin
      w_need_z  = 1'b0;
      w_need_nv = 1'b0;
      case (br_cc)
         3'b000, 3'b001:         w_need_z  = 1'b1;
         3'b010, 3'b100, 3'b101: begin
            w_need_z  = 1'b1;
            w_need_nv = 1'b1;
         end
         3'b011, 3'b110:         w_need_nv = 1'b1;
         default: ;
      endcase
   end

   assign w_z_pend   = (|r_z0)  | (|r_z1);
   assign w_nv_pend  = (|r_nv0) | (|r_nv1);
   assign br_stall   = br_id & ~flush & ((w_need_z & w_z_pend) | (w_need_nv & w_nv_pend));
   assign w_issue_ok = ~hold & ~br_stall & ~flush;

   assign w_z_last0  = r_z0[LAT-1];
   assign w_z_last1  = r_z1[LAT-1];
   assign w_nv_last0 = r_nv0[LAT-1];
   assign w_nv_last1 = r_nv1[LAT-1];

   // Younger lane wins when both lanes land the same flag together.
   assign clk_z_ID_EX      = ~hold & w_z_last0 & ~w_z_last1;
   assign clk_z_ID_ext_EX  = ~hold & w_z_last1;
   assign clk_nv_ID_EX     = ~hold & w_nv_last0 & ~w_nv_last1;
   assign clk_nv_ID_ext_EX = ~hold & w_nv_last1;

   assign flags_busy = w_z_pend | w_nv_pend;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_z0  <= '0;
         r_nv0 <= '0;
         r_z1  <= '0;
         r_nv1 <= '0;
      end else if (flush) begin
         r_z0  <= '0;
         r_nv0 <= '0;
         r_z1  <= '0;
         r_nv1 <= '0;
      end else if (!hold) begin
         r_z0  <= f_shift(r_z0,  w_issue_ok & issue_vld0 & wz0);
         r_nv0 <= f_shift(r_nv0, w_issue_ok & issue_vld0 & wnv0);
         r_z1  <= f_shift(r_z1,  w_issue_ok & issue_vld1 & wz1);
         r_nv1 <= f_shift(r_nv1, w_issue_ok & issue_vld1 & wnv1);
      end
   end

`ifdef FLAG_STATS_EN
   logic [CNT_W-1:0] r_stall_cnt;

   // Saturating count of non-held branch stall cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_cnt <= '0;
      end else if (br_stall && !hold && (r_stall_cnt != {CNT_W{1'b1}})) begin
         r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
   end

   assign br_stall_cnt = r_stall_cnt;
`endif

endmodule

// File: doc/flag_wr_sched.md
Name: flag_wr_sched

Overview:
- Flag-write scheduler and branch interlock for the dual-lane in-order core.
- Lane 0 feeds the main ALU; lane 1 feeds the ext ALU and is always the younger instruction of an issue pair.
- Tracks in-flight Z and N/V flag writers from ID to EX and generates the four flag-flop clock enables for the branch-resolution logic.
- Stalls a branch in ID until every older writer of the flags its condition code reads has landed.

Parameters:
- LAT, 2: cycles from ID issue to the EX flag write; legal range 1..4.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- hold  input  1  global pipeline stall; freezes all tracking state
- flush  input  1  squash all in-flight instructions (taken branch/jump)
- issue_vld0  input  1  lane-0 instruction valid in ID
- wz0  input  1  lane-0 instruction writes Z
- wnv0  input  1  lane-0 instruction writes N and V
- issue_vld1  input  1  lane-1 instruction valid in ID
- wz1  input  1  lane-1 instruction writes Z
- wnv1  input  1  lane-1 instruction writes N and V
- br_id  input  1  lane-0 ID instruction is a conditional branch
- br_cc  input  3  branch condition code
- clk_z_ID_EX  output  1  load Z from the main ALU
- clk_nv_ID_EX  output  1  load N/V from the main ALU
- clk_z_ID_ext_EX  output  1  load Z from the ext ALU
- clk_nv_ID_ext_EX  output  1  load N/V from the ext ALU
- br_stall  output  1  hold ID/IF; branch operands are not ready
- flags_busy  output  1  any flag writer is in flight

Behaviour:
- Reset: all tracking stages cleared; every output is 0. Reset is asynchronous and takes effect mid-operation, discarding any in-flight state.
- Tracking: four shift registers, each LAT deep: z0, nv0, z1, nv1.
- Issue: issue_ok = ~hold & ~br_stall & ~flush. When issue_ok is 1, stage 0 of each register loads its lane's write bit ANDed with that lane's issue_vld. Otherwise stage 0 loads 0, i.e. a bubble.
- Shift: when ~hold, entries advance one stage per cycle. When hold is 1, all stages keep their values.
- Write enables: asserted combinationally from the last stage and only when ~hold. The flag flop updates on the following edge.
- Same-flag collision: if z0 and z1 both sit in the last stage, only clk_z_ID_ext_EX asserts, so the younger lane wins. The same rule applies to nv0/nv1. Z and N/V are resolved independently.
- Flush: on the edge where flush=1, all stages clear. Enables already asserted in that cycle still take effect, because those instructions are older than the flushing branch.
- Flags needed by br_cc:
  - 000, 001: Z
  - 010, 100, 101: Z and N/V
  - 011: N/V
  - 110: N/V
  - 111: none
- Pending: a flag class is pending if any stage of either lane's register for that class is set, including the last stage.
- br_stall = br_id & ~flush & (needed Z pending | needed N/V pending). br_stall is independent of hold.
- A lane-1 writer issued together with the branch is younger, so it never blocks that branch.
- Latency: a branch that issues directly behind a writer stalls exactly LAT cycles (no hold).
- A cc=111 branch never stalls.
- flags_busy = OR of all stages.

Optional Feature:
- Macro: FLAG_STATS_EN.
- When defined: adds output br_stall_cnt, 16 bits.
  - Increments on every cycle where br_stall=1 and hold=0.
  - Saturates at 16'hFFFF.
  - Cleared only by reset.
- When undefined: the port and counter are absent, and all other behaviour is identical.

Test Plan:
- LAT=2. Issue lane0 wz0=1, then br_id cc=000 the next cycle -> br_stall=1 for 2 cycles; clk_z_ID_EX=1 in the second stall cycle; branch proceeds in the third cycle.
- Same cycle: lane0 wz0=1 and lane1 wz1=1 -> two cycles later clk_z_ID_ext_EX=1 and clk_z_ID_EX=0.
- Lane0 wnv0=1, then br_id cc=001 (Z only) -> br_stall=0 throughout; clk_nv_ID_EX=1 two cycles after issue.
- Writer in flight, assert hold for 3 cycles -> no enables and stages frozen while hold=1; the enable appears the expected number of non-hold cycles after issue.
- Writer at stage 0 plus a stalled branch, then pulse flush -> stages clear next edge; no later enable; br_stall=0; flags_busy=0.
- FLAG_STATS_EN defined, run the first scenario twice -> br_stall_cnt=4. Assert rst_n low mid-stall -> count=0 and all outputs 0 immediately.
